new_sched_unit: RTL and testbench



---
 rtl/new_sched_unit.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_new_sched_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/new_sched_unit.sv
// ============================================================================
// new_sched_unit
// ----------------------------------------------------------------------------
// GPU task scheduler. Walks a task program stored in a flat word array, decodes
// each three-word task header, waits until the target cores are idle and the
// ordering rules (per-core reservations, exclusive tasks, barriers) allow it,
// then streams every word of the task to the selected cores one word per beat.
//
// Task layout at word pointer P:
//   w0      flags: [5:0] frame count minus one, [6] EXCL, [7] BARRIER
//   w1      core mask (cores that receive the frames)
//   w2      completion mask (cores that must be free for the task to count
//           as finished; used to release an EXCL block)
//   w3..    R0 init data followed by instructions, all streamed verbatim
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous, active-high
//   core_ready       in   per-core idle flag (1 = idle)
//   core_reading     in   cores accept the current bus word this cycle
//   prog_loading     in   program memory being written; scheduler held idle
//   data_frames_in   in   task program memory
//   bus_data         out  word currently offered on the core bus
//   bus_core_mask    out  cores addressed by the current frame
//   frame_being_sent out  high while a frame is on the bus
//   sched_done       out  program finished
// ============================================================================
module new_sched_unit #(
    parameter int DATA_DEPTH     = 1024,
    parameter int R0_DATA_SIZE   = 128,
    parameter int CTRL_DATA_SIZE = 48,
    parameter int INSTR_SIZE     = 16,
    parameter int FRAME_SIZE     = 256,
    parameter int FRAME_NUM      = 64,
    parameter int CORE_NUM       = 16,
    parameter int BUS_TO_CORE    = 16,
    parameter int R0_DEPTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CORE_NUM-1:0]                   core_ready,
    input  logic                                  core_reading,
    input  logic                                  prog_loading,
    input  logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] data_frames_in,
    output logic [BUS_TO_CORE-1:0]                bus_data,
    output logic [CORE_NUM-1:0]                   bus_core_mask,
    output logic                                  frame_being_sent,
    output logic                                  sched_done
);

    localparam int WORDS_PER_FRAME = FRAME_SIZE / INSTR_SIZE;
    localparam int BEAT_W          = $clog2(WORDS_PER_FRAME);
    localparam int FRAME_W         = $clog2(FRAME_NUM);
    localparam int ADDR_W          = $clog2(DATA_DEPTH);
    // One extra bit so the pointer can sit at DATA_DEPTH after the last task.
    localparam int PTR_W           = ADDR_W + 1;
    localparam int HDR_WORDS       = CTRL_DATA_SIZE / INSTR_SIZE;

    // The header plus the R0 block must fit inside the first frame of a task;
    // a parameter set that breaks this layout elaborates the marker block below.
    if ((R0_DATA_SIZE != R0_DEPTH * INSTR_SIZE) ||
        (HDR_WORDS + R0_DEPTH > WORDS_PER_FRAME)) begin : g_layout_unsupported
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_FREE,
        RES_RESERVED,
        RES_RUNNING
    } res_t;

    state_t state;
    state_t next_state;

    logic [PTR_W-1:0]    ptr;
    logic [BEAT_W-1:0]   beat;
    logic [FRAME_W-1:0]  frame;

    logic [FRAME_W-1:0]  task_frames;
    logic                task_excl;
    logic                task_barrier;
    logic [CORE_NUM-1:0] task_mask;
    logic [CORE_NUM-1:0] task_done_mask;

    res_t                res_state [CORE_NUM];
    logic [CORE_NUM-1:0] reserved_vec;
    logic                excl_pending;
    logic [CORE_NUM-1:0] excl_mask;

    logic [INSTR_SIZE-1:0] hdr0;
    logic [INSTR_SIZE-1:0] hdr1;
    logic [INSTR_SIZE-1:0] hdr2;
    logic [PTR_W-1:0]      stream_addr;
    logic [INSTR_SIZE-1:0] stream_word;
    logic [PTR_W-1:0]      task_len;

    logic cores_ok;
    logic free_ok;
    logic barrier_ok;
    logic dispatch;
    logic reserve_now;
    logic last_beat;
    logic last_frame;
    logic end_of_mem;
    logic excl_complete;

    // Reads past the end of program memory return zero, which also makes a
    // header fetched beyond the array look like an end-of-program marker.
    function automatic logic [INSTR_SIZE-1:0] read_word(input logic [PTR_W-1:0] addr);
        if (addr < PTR_W'(DATA_DEPTH)) begin
            return data_frames_in[addr[ADDR_W-1:0]];
        end
        return '0;
    endfunction

    // Address decode: header words at the pointer, and the streaming address
    // which is the task start plus the frame/beat offset within the task.
    always_comb begin
        hdr0        = read_word(ptr);
        hdr1        = read_word(ptr + PTR_W'(1));
        hdr2        = read_word(ptr + PTR_W'(2));
        stream_addr = ptr + PTR_W'({frame, beat});
        stream_word = read_word(stream_addr);
        task_len    = (PTR_W'(task_frames) + PTR_W'(1)) << BEAT_W;
    end

    // A core counts as reserved until it has gone busy and come back idle.
    always_comb begin
        reserved_vec = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            reserved_vec[i] = (res_state[i] != RES_FREE);
        end
    end

    // Dispatch rules for the task latched in FETCH. The EXCL block uses the
    // registered flag, so a task after an exclusive one dispatches at the
    // earliest one cycle after the exclusive task's completion cores free up.
    always_comb begin
        cores_ok      = ((core_ready & task_mask) == task_mask);
        free_ok       = ((task_mask & reserved_vec) == '0);
        barrier_ok    = !task_barrier || ((&core_ready) && (reserved_vec == '0));
        dispatch      = cores_ok && free_ok && !excl_pending && barrier_ok;
        reserve_now   = (state == S_CHECK) && dispatch && !prog_loading;
        last_beat     = (beat == BEAT_W'(WORDS_PER_FRAME - 1));
        last_frame    = (frame == task_frames);
        end_of_mem    = (stream_addr == PTR_W'(DATA_DEPTH - 1));
        excl_complete = ((excl_mask & reserved_vec) == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. prog_loading overrides everything and parks the
    // scheduler in IDLE; DONE only leaves through reset or a new program load.
    always_comb begin
        next_state = state;
        if (prog_loading) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = S_FETCH;
                S_FETCH: begin
                    if ((ptr >= PTR_W'(DATA_DEPTH)) || (hdr0 == '0)) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dispatch) begin
                        next_state = S_SEND;
                    end
                end
                S_SEND: begin
                    if (core_reading) begin
                        if (end_of_mem) begin
                            next_state = S_DONE;
                        end else if (last_beat) begin
                            next_state = last_frame ? S_FETCH : S_GAP;
                        end
                    end
                end
                S_GAP:  next_state = S_SEND;
                S_DONE: next_state = S_DONE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Pointer, beat and frame counters plus the latched task header. The beat
    // counter wraps naturally at the end of a frame; the frame counter only
    // advances in the one-cycle gap between frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr            <= '0;
            beat           <= '0;
            frame          <= '0;
            task_frames    <= '0;
            task_excl      <= 1'b0;
            task_barrier   <= 1'b0;
            task_mask      <= '0;
            task_done_mask <= '0;
        end else if (prog_loading) begin
            ptr   <= '0;
            beat  <= '0;
            frame <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    task_frames    <= hdr0[FRAME_W-1:0];
                    task_excl      <= hdr0[6];
                    task_barrier   <= hdr0[7];
                    task_mask      <= hdr1[CORE_NUM-1:0];
                    task_done_mask <= hdr2[CORE_NUM-1:0];
                end
                S_CHECK: begin
                    if (dispatch) begin
                        beat  <= '0;
                        frame <= '0;
                    end
                end
                S_SEND: begin
                    if (core_reading) begin
                        beat <= beat + BEAT_W'(1);
                        if (end_of_mem) begin
                            ptr <= PTR_W'(DATA_DEPTH);
                        end else if (last_beat && last_frame) begin
                            ptr <= ptr + task_len;
                        end
                    end
                end
                S_GAP: begin
                    frame <= frame + FRAME_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Per-core reservation tracking. Dispatch reserves the task's cores; each
    // one must be seen busy and then idle again before it is free, so a core
    // that simply stays idle after dispatch keeps its reservation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CORE_NUM; i++) begin
                res_state[i] <= RES_FREE;
            end
        end else begin
            for (int i = 0; i < CORE_NUM; i++) begin
                if (reserve_now && task_mask[i]) begin
                    res_state[i] <= RES_RESERVED;
                end else begin
                    case (res_state[i])
                        RES_RESERVED: if (!core_ready[i]) res_state[i] <= RES_RUNNING;
                        RES_RUNNING:  if (core_ready[i])  res_state[i] <= RES_FREE;
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Exclusive-task block: armed when an EXCL task dispatches and released
    // once every core in that task's completion mask is free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            excl_pending <= 1'b0;
            excl_mask    <= '0;
        end else if (reserve_now && task_excl) begin
            excl_pending <= 1'b1;
            excl_mask    <= task_done_mask;
        end else if (excl_pending && excl_complete) begin
            excl_pending <= 1'b0;
        end
    end

    // Output decode. Outputs go quiet immediately while a program is loading.
    always_comb begin
        bus_data         = '0;
        bus_core_mask    = '0;
        frame_being_sent = 1'b0;
        sched_done       = 1'b0;
        if (!prog_loading) begin
            case (state)
                S_SEND: begin
                    frame_being_sent = 1'b1;
                    bus_core_mask    = task_mask;
                    bus_data         = BUS_TO_CORE'(stream_word);
                end
                S_DONE: begin
                    sched_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_new_sched_unit.sv
// ============================================================================
// tb_new_sched_unit
// ----------------------------------------------------------------------------
// Self-checking bench for new_sched_unit. The reference model walks the task
// program the same way a programmer would read it (header, length, masks) and
// produces the ordered list of words, masks and frame boundaries the cores
// must receive; a negedge monitor compares every bus cycle against it.
// ============================================================================
module tb_new_sched_unit;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [15:0] w0, w1, w2, ready;
        logic        exp_fbs;
        logic [15:0] exp_mask, exp_data;
        logic        exp_done;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] mask;
        bit          frame_end;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [15:0]            core_ready;
    logic                   core_reading;
    logic                   prog_loading;
    logic [DEPTH-1:0][15:0] mem;
    logic [15:0]            bus_data;
    logic [15:0]            bus_core_mask;
    logic                   frame_being_sent;
    logic                   sched_done;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    bit    mon_en  = 1'b0;
    bit    gap_due = 1'b0;
    vec_t  vecs[7];

    new_sched_unit dut (
        .clk              (clk),
        .reset            (reset),
        .core_ready       (core_ready),
        .core_reading     (core_reading),
        .prog_loading     (prog_loading),
        .data_frames_in   (mem),
        .bus_data         (bus_data),
        .bus_core_mask    (bus_core_mask),
        .frame_being_sent (frame_being_sent),
        .sched_done       (sched_done)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_at(input int a);
        return (a < DEPTH) ? mem[a] : 16'h0000;
    endfunction

    // Reference model: expected word stream of the whole program in mem.
    task automatic build_model();
        int p;
        p = 0;
        exp_q.delete();
        while (p < DEPTH && word_at(p) != 16'h0000) begin
            int          len;
            logic [15:0] m;
            len = (int'(word_at(p) & 16'h003F) + 1) * 16;
            m   = word_at(p + 1);
            for (int k = 0; k < len && p + k < DEPTH; k++) begin
                beat_t b;
                b.data      = mem[p + k];
                b.mask      = m;
                b.frame_end = ((k % 16) == 15);
                exp_q.push_back(b);
            end
            p += len;
        end
    endtask

    // Bus monitor: every sending cycle must show the next expected word, and
    // the cycle after each 16th accepted word must be a gap.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gap_due) begin
                checkOutput("frame_gap", {31'd0, frame_being_sent}, 32'd0);
                gap_due = 1'b0;
            end
            if (frame_being_sent) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat", {16'd0, bus_data}, 32'hDEAD_BEEF);
                end else begin
                    checkOutput("beat_data", {16'd0, bus_data}, {16'd0, exp_q[0].data});
                    checkOutput("beat_mask", {16'd0, bus_core_mask}, {16'd0, exp_q[0].mask});
                    if (core_reading) begin
                        gap_due = exp_q[0].frame_end;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        mon_en       = 1'b0;
        gap_due      = 1'b0;
        reset        = 1'b1;
        prog_loading = 1'b1;
        core_reading = 1'b0;
        core_ready   = 16'hFFFF;
        mem          = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'($urandom);
        end
    endtask

    // Single-task scenario from the vector table, left stalled on the bus.
    task automatic applyStimulus(input vec_t v);
        reset_dut();
        mem[0]       = v.w0;
        mem[1]       = v.w1;
        mem[2]       = v.w2;
        core_ready   = v.ready;
        core_reading = 1'b0;
        tick();
        prog_loading = 1'b0;
        repeat (20) tick();
    endtask

    task automatic wait_queue(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() > target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, exp_q.size(), target);
    endtask

    task automatic quiet(input int cycles, input string name);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            tick();
            if (frame_being_sent) seen = 1'b1;
        end
        checkOutput(name, {31'd0, seen}, 32'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!sched_done && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, sched_done}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        prog_loading = 1'b1;
        core_reading = 1'b0;
        core_ready   = 16'hFFFF;
        mem          = '0;

        vecs[0] = '{16'h0043, 16'h000F, 16'h000F, 16'hFFFF, 1'b1, 16'h000F, 16'h0043, 1'b0};
        vecs[1] = '{16'h0003, 16'h00F0, 16'h00F0, 16'hFF0F, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{16'h008F, 16'h0F00, 16'h0F00, 16'hFF0F, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h008F, 16'h0F00, 16'h0F00, 16'hFFFF, 1'b1, 16'h0F00, 16'h008F, 1'b0};
        vecs[4] = '{16'h0000, 16'h000F, 16'h000F, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{16'h0101, 16'h0001, 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{16'h0100, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h8000, 16'h0100, 1'b0};

        tick();
        checkOutput("reset_fbs",  {31'd0, frame_being_sent}, 32'd0);
        checkOutput("reset_done", {31'd0, sched_done}, 32'd0);
        checkOutput("reset_mask", {16'd0, bus_core_mask}, 32'd0);
        checkOutput("reset_data", {16'd0, bus_data}, 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_fbs", i),  {31'd0, frame_being_sent}, {31'd0, vecs[i].exp_fbs});
            checkOutput($sformatf("vec%0d_mask", i), {16'd0, bus_core_mask}, {16'd0, vecs[i].exp_mask});
            checkOutput($sformatf("vec%0d_data", i), {16'd0, bus_data}, {16'd0, vecs[i].exp_data});
            checkOutput($sformatf("vec%0d_done", i), {31'd0, sched_done}, {31'd0, vecs[i].exp_done});
        end

        $display("[TB] ordering chain: EXCL, reservation, barrier");
        reset_dut();
        fill_random();
        for (int i = 512; i < DEPTH; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h0043; mem[1]   = 16'h000F; mem[2]   = 16'h000F;
        mem[64]  = 16'h0003; mem[65]  = 16'h00F0; mem[66]  = 16'h00F0;
        mem[128] = 16'h0007; mem[129] = 16'h00F0; mem[130] = 16'h00F0;
        mem[256] = 16'h008F; mem[257] = 16'h0F00; mem[258] = 16'h0F00;
        build_model();
        checkOutput("chain_model_len", exp_q.size(), 512);
        core_ready   = 16'hFFFF;
        core_reading = 1'b1;
        mon_en       = 1'b1;
        prog_loading = 1'b0;
        wait_queue(448, 300, "task0_sent");
        quiet(30, "excl_hold");
        core_ready = 16'hFFF0;
        repeat (2) tick();
        core_ready = 16'hFFFF;
        wait_queue(384, 300, "task1_sent");
        quiet(30, "reserve_hold");
        core_ready = 16'hFF0F;
        repeat (2) tick();
        core_ready = 16'hFFFF;
        wait_queue(256, 400, "task2_sent");
        core_ready = 16'hFF0F;
        quiet(30, "barrier_hold");
        core_ready = 16'hFFFF;
        wait_queue(0, 600, "task3_sent");
        wait_done(10, "chain_done");
        checkOutput("done_bus_data", {16'd0, bus_data}, 32'd0);
        checkOutput("done_bus_mask", {16'd0, bus_core_mask}, 32'd0);

        $display("[TB] reload after done");
        prog_loading = 1'b1;
        repeat (2) tick();
        checkOutput("reload_done_low", {31'd0, sched_done}, 32'd0);
        checkOutput("reload_fbs_low",  {31'd0, frame_being_sent}, 32'd0);
        mem = '0;
        for (int i = 3; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0100; mem[1] = 16'h0001; mem[2] = 16'h0001;
        build_model();
        tick();
        prog_loading = 1'b0;
        wait_queue(0, 100, "reload_from_zero");
        wait_done(10, "reload_done");

        $display("[TB] reset during send");
        reset_dut();
        mem[0] = 16'h0043; mem[1] = 16'h000F; mem[2] = 16'h000F;
        core_reading = 1'b1;
        prog_loading = 1'b0;
        begin
            int n;
            n = 0;
            while (!frame_being_sent && n < 10) begin
                tick();
                n++;
            end
        end
        checkOutput("pre_reset_send", {31'd0, frame_being_sent}, 32'd1);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_fbs",  {31'd0, frame_being_sent}, 32'd0);
        checkOutput("abort_mask", {16'd0, bus_core_mask}, 32'd0);
        checkOutput("abort_data", {16'd0, bus_data}, 32'd0);
        tick();
        reset = 1'b0;

        $display("[TB] task truncated at end of memory");
        reset_dut();
        fill_random();
        mem[0]   = 16'h013D; mem[1]   = 16'h0001; mem[2]   = 16'h0001;
        mem[992] = 16'h0102; mem[993] = 16'h0002; mem[994] = 16'h0002;
        build_model();
        checkOutput("trunc_model_len", exp_q.size(), 1024);
        core_reading = 1'b1;
        mon_en       = 1'b1;
        prog_loading = 1'b0;
        wait_queue(0, 1300, "trunc_stream");
        wait_done(10, "trunc_done");

        $display("[TB] random program with random core activity");
        reset_dut();
        fill_random();
        begin
            int p;
            p = 0;
            while (p < DEPTH) begin
                int          fr;
                logic [15:0] hdr;
                logic [15:0] m;
                fr       = $urandom_range(1, 4);
                hdr      = 16'($urandom);
                hdr[8]   = 1'b1;
                hdr[7]   = ($urandom_range(0, 9) == 0);
                hdr[6]   = ($urandom_range(0, 3) == 0);
                hdr[5:0] = 6'(fr - 1);
                m        = 16'($urandom);
                if (m == 16'h0000) m = 16'h0001;
                mem[p]     = hdr;
                mem[p + 1] = m;
                mem[p + 2] = m;
                p += fr * 16;
            end
        end
        build_model();
        mon_en       = 1'b1;
        prog_loading = 1'b0;
        begin
            int n;
            n = 0;
            while (!sched_done && n < 30000) begin
                tick();
                core_reading = 1'($urandom_range(0, 1));
                core_ready   = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
                n++;
            end
        end
        checkOutput("rand_done", {31'd0, sched_done}, 32'd1);
        checkOutput("rand_remaining", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
